// File: rtl/multi_toggle_gen.sv
`default_nettype none
// ============================================================================
// Module   : multi_toggle_gen
// Purpose  : N-channel square-wave stimulus generator. Channel i toggles with
//            a half-period of (i+1)*BASE clock cycles during a run of
//            programmable length. A registered OR/AND/XOR/NOR reduction of the
//            live pattern serves as the reference for a gate under test.
// Ports    : clk        - rising-edge clock
//            rst_n      - synchronous active-low reset
//            start      - run request, sampled in IDLE only
//            stop       - abort request, sampled in RUN only
//            run_len    - run length in cycles, captured on accepted start
//            mode       - reduction select: 00 OR, 01 AND, 10 XOR, 11 NOR
//            pattern    - channel outputs, bit i is channel i
//            reduce_out - registered reduction of pattern per mode
//            busy       - high while in RUN
//            done       - one-cycle pulse on normal completion
// Config   : MULTI_TOGGLE_GEN_REDUCE_EN - when defined, builds the reduction
//            logic; otherwise reduce_out is tied to 0 and mode is unused.
// Revision : 1.0 - initial release
// ============================================================================
module multi_toggle_gen #(
  parameter int CH    = 4,
  parameter int BASE  = 50,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic [CNT_W-1:0] run_len,
  input  logic [1:0]       mode,
  output logic [CH-1:0]    pattern,
  output logic             reduce_out,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt [CH];
  logic [CNT_W-1:0] elapsed;
  logic [CNT_W-1:0] len_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      pattern <= '0;
      elapsed <= '0;
      len_q   <= '0;
      for (int i = 0; i < CH; i++) cnt[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            pattern <= '0;
            elapsed <= '0;
            len_q   <= run_len;
            for (int i = 0; i < CH; i++) cnt[i] <= '0;
            state   <= (run_len == '0) ? DONE : RUN;
          end
        end
        RUN: begin
          // Each channel wraps at its own terminal count and flips its bit.
          for (int i = 0; i < CH; i++) begin
            if (cnt[i] == CNT_W'((i + 1) * BASE - 1)) begin
              cnt[i]     <= '0;
              pattern[i] <= ~pattern[i];
            end else begin
              cnt[i] <= cnt[i] + CNT_W'(1);
            end
          end
          elapsed <= elapsed + CNT_W'(1);
          // Abort wins over completion on the same edge; the pattern update
          // above still lands, so the output freezes at this edge's value.
          if (stop)
            state <= IDLE;
          else if (elapsed == len_q - CNT_W'(1))
            state <= DONE;
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

`ifdef MULTI_TOGGLE_GEN_REDUCE_EN
  logic red_next;

  always_comb begin
    red_next = 1'b0;
    case (mode)
      2'b00:   red_next = |pattern;
      2'b01:   red_next = &pattern;
      2'b10:   red_next = ^pattern;
      default: red_next = ~|pattern;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) reduce_out <= 1'b0;
    else        reduce_out <= red_next;
  end
`else
  logic unused_mode;
  assign unused_mode = ^mode;
  assign reduce_out  = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_multi_toggle_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_multi_toggle_gen
// Purpose  : Directed self-checking bench for multi_toggle_gen (CH=4, BASE=2).
//            Expected patterns come from the closed-form toggle rule: after n
//            RUN edges, bit i = floor(n / ((i+1)*BASE)) mod 2.
// Revision : 1.0 - initial release
// ============================================================================
module tb_multi_toggle_gen;

  localparam int CH    = 4;
  localparam int BASE  = 2;
  localparam int CNT_W = 16;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic             stop;
  logic [CNT_W-1:0] run_len;
  logic [1:0]       mode;
  logic [CH-1:0]    pattern;
  logic             reduce_out;
  logic             busy;
  logic             done;

  int n_assert = 0;
  int n_fail   = 0;

  logic [CH-1:0] model_pat = '0;
  logic [CH-1:0] prev_pat  = '0;
  logic          rst_active = 1'b1;

  multi_toggle_gen #(.CH(CH), .BASE(BASE), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .stop       (stop),
    .run_len    (run_len),
    .mode       (mode),
    .pattern    (pattern),
    .reduce_out (reduce_out),
    .busy       (busy),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [CH-1:0] pat_at(input int n);
    logic [CH-1:0] p;
    for (int i = 0; i < CH; i++) p[i] = ((n / ((i + 1) * BASE)) % 2) == 1;
    return p;
  endfunction

  function automatic logic red(input logic [CH-1:0] p, input logic [1:0] m);
`ifdef MULTI_TOGGLE_GEN_REDUCE_EN
    case (m)
      2'b00:   return |p;
      2'b01:   return &p;
      2'b10:   return ^p;
      default: return ~|p;
    endcase
`else
    return 1'b0;
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    prev_pat = model_pat;
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input logic exp_busy, input logic exp_done);
    check({tag, ".pattern"}, 32'(pattern), 32'(model_pat));
    check({tag, ".busy"},    32'(busy),    32'(exp_busy));
    check({tag, ".done"},    32'(done),    32'(exp_done));
    check({tag, ".reduce"},  32'(reduce_out),
          32'(rst_active ? 1'b0 : red(prev_pat, mode)));
  endtask

  // Start a run and follow it edge by edge; restart_at > 0 pulses start
  // before that RUN edge, and a start is also offered during the DONE cycle.
  task automatic run_task(input string tag, input int len, input logic [1:0] md,
                          input int restart_at);
    run_len = CNT_W'(len);
    mode    = md;
    start   = 1'b1;
    tick();
    start     = 1'b0;
    model_pat = '0;
    check_all({tag, ".start"}, len != 0, len == 0);
    for (int n = 1; n <= len; n++) begin
      if (n == restart_at) start = 1'b1;
      tick();
      start     = 1'b0;
      model_pat = pat_at(n);
      check_all({tag, ".run"}, n < len, n == len);
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    check_all({tag, ".idle"}, 1'b0, 1'b0);
  endtask

  initial begin
    rst_n   = 1'b0;
    start   = 1'b1;
    stop    = 1'b0;
    run_len = CNT_W'(5);
    mode    = 2'b00;

    // Reset held for 3 cycles with start asserted.
    rst_active = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check_all("reset", 1'b0, 1'b0);
    end
    start = 1'b0;
    rst_n = 1'b1;
    rst_active = 1'b0;
    tick();
    check_all("post_reset", 1'b0, 1'b0);

    // Full run for each reduction mode; 16 RUN edges land on 4'b0000.
    run_task("run_or",  16, 2'b00, 0);
    check("final_or", 32'(pattern), 32'(4'b0000));
    run_task("run_and", 16, 2'b01, 0);
    run_task("run_xor", 16, 2'b10, 0);
    run_task("run_nor", 16, 2'b11, 0);

    // Start during RUN must not restart the counters.
    run_task("restart", 8, 2'b10, 4);

    // Zero-length run (stop in IDLE ignored).
    stop = 1'b1;
    run_task("zero", 0, 2'b00, 0);
    stop = 1'b0;

    // Stop on the 10th RUN edge of a 10-cycle run: no done, frozen 4'b1101.
    run_len = CNT_W'(10);
    mode    = 2'b10;
    start   = 1'b1;
    tick();
    start     = 1'b0;
    model_pat = '0;
    check_all("stop.start", 1'b1, 1'b0);
    for (int n = 1; n <= 10; n++) begin
      if (n == 10) stop = 1'b1;
      tick();
      model_pat = pat_at(n);
      check_all("stop.run", n < 10, 1'b0);
    end
    stop = 1'b0;
    check("stop_frozen", 32'(pattern), 32'(4'b1101));
    tick();
    check_all("stop.hold", 1'b0, 1'b0);
    tick();
    check_all("stop.hold2", 1'b0, 1'b0);

    // Reset during RUN cycle 5.
    run_len = CNT_W'(16);
    mode    = 2'b00;
    start   = 1'b1;
    tick();
    start     = 1'b0;
    model_pat = '0;
    check_all("mrst.start", 1'b1, 1'b0);
    for (int n = 1; n <= 4; n++) begin
      tick();
      model_pat = pat_at(n);
      check_all("mrst.run", 1'b1, 1'b0);
    end
    rst_n = 1'b0;
    tick();
    rst_active = 1'b1;
    model_pat  = '0;
    check_all("mrst.reset", 1'b0, 1'b0);
    rst_n = 1'b1;
    tick();
    rst_active = 1'b0;
    check_all("mrst.after", 1'b0, 1'b0);
    for (int k = 0; k < 20; k++) begin
      tick();
      check_all("mrst.nodone", 1'b0, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
